cfg_frame_writer_icc: RTL
=========================

CFG_FRAME_WRITER_ICC -- requirements
Module: cfg_frame_writer_icc

Interface
REQ-001 SHALL have parameter FRAME_W, default 32, meaning data bits per configuration frame.
REQ-002 SHALL have parameter NFRAMES, default 8, meaning frames per tile; address width is 3.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstb  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins or restarts a configuration load.
REQ-006 SHALL have port sdi  input  1  serial configuration bit.
REQ-007 SHALL have port sdi_vld  input  1  sdi holds a valid bit.
REQ-008 SHALL have port sdi_rdy  output  1  block accepts a bit this cycle.
REQ-009 SHALL have port cbit  output  FRAME_W*NFRAMES  true configuration bits to the muxes.
REQ-010 SHALL have port cbitb  output  FRAME_W*NFRAMES  complement configuration bits.
REQ-011 SHALL have port prog  output  1  programming-mode flag; high forces the muxes safe.
REQ-012 SHALL have port done  output  1  configuration complete and fabric released.
REQ-013 SHALL have port err  output  1  sticky parity-error flag.
REQ-014 SHALL have port rb_req  input  1  readback request pulse.
REQ-015 SHALL have port rb_addr  input  3  frame to read back.
REQ-016 SHALL have port rb_data  output  FRAME_W  read-back frame contents.
REQ-017 SHALL have port rb_vld  output  1  rb_data valid, one-cycle pulse.

Function
REQ-018 SHALL implement states IDLE, LOAD, WAKE and RUN.
REQ-019 Transitions: IDLE->LOAD on start; LOAD->WAKE when all NFRAMES mask bits are set; WAKE->RUN after exactly 2 cycles; RUN->LOAD on start.
REQ-020 A start pulse in LOAD or WAKE SHALL restart LOAD and clear the bit counter, the frame mask and err.
REQ-021 sdi_rdy SHALL be high only in LOAD; a bit is consumed only when sdi_vld and sdi_rdy are both high.
REQ-022 A frame is 36 consumed bits, sent LSB first: 3-bit address, FRAME_W data bits, then 1 even-parity bit covering address and data.
REQ-023 On the edge that consumes bit 36, a frame with good parity SHALL write cbit[addr*32 +: 32] and set mask[addr].
REQ-024 On the same edge, a frame with bad parity SHALL be discarded and SHALL set err.
REQ-025 The bit counter SHALL wrap to 0 after every 36th bit, whether parity was good or bad.
REQ-026 Writing an address already in the mask SHALL overwrite that frame; the mask bit stays set.
REQ-027 sdi_rdy SHALL fall in the cycle after the bit that completes the mask.
REQ-028 cbitb SHALL equal ~cbit bitwise at all times, including during reset, and SHALL come from the same register bank.
REQ-029 prog SHALL be high in IDLE, LOAD and WAKE, and low only in RUN.
REQ-030 done SHALL be high only in RUN.
REQ-031 Restarting from RUN SHALL retain cbit contents until each frame is rewritten; prog rises on the edge entering LOAD.
REQ-032 On rb_req, the block SHALL register the frame at rb_addr onto rb_data and pulse rb_vld the next cycle; readback is legal in every state.
REQ-033 When rb_req coincides with a write to the same frame, rb_data SHALL return the pre-write contents.

Reset
REQ-034 While rstb is low, outputs SHALL be: state IDLE, cbit all 0, cbitb all 1, prog 1, done 0, err 0, sdi_rdy 0, rb_vld 0, rb_data 0; the bit counter and mask SHALL be cleared.
REQ-035 Reset asserted mid-frame or mid-WAKE SHALL abandon the partial frame; no partial write reaches cbit.

Verification
REQ-036 Reset, start, then 8 good frames with addr k and data 32'hA5A5_0000+k -> cbit holds those frames, cbitb is the exact complement, WAKE lasts 2 cycles, then prog=0 and done=1.
REQ-037 Flipped parity bit in frame 3 -> err=1, frame 3 unchanged (0), mask incomplete, prog stays 1; resend frame 3 correctly -> RUN is reached, err stays 1.
REQ-038 sdi_vld toggled randomly 50% during load -> results identical to the REQ-036 scenario; no bit is consumed while sdi_vld=0.
REQ-039 rstb pulsed low after bit 20 of frame 5 -> all outputs match REQ-034 immediately; a following full load succeeds.
REQ-040 In RUN, start then rewrite only frame 0 with 32'hFFFF_FFFF -> prog=1, frames 1-7 retained, mask incomplete, done=0.
REQ-041 rb_req for addr 2 on the same edge that writes addr 2 -> rb_vld=1 next cycle with the old data; a repeated request returns the new data.

Source files
------------

// File: rtl/cfg_frame_writer_icc.sv
// Serial configuration frame loader: collects address/data/parity frames into a
// configuration bank, gates the fabric through WAKE, and supports frame readback.
module cfg_frame_writer_icc #(
    parameter int FRAME_W = 32,
    parameter int NFRAMES = 8
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       start,
    input  logic                       sdi,
    input  logic                       sdi_vld,
    output logic                       sdi_rdy,
    output logic [FRAME_W*NFRAMES-1:0] cbit,
    output logic [FRAME_W*NFRAMES-1:0] cbitb,
    output logic                       prog,
    output logic                       done,
    output logic                       err,
    input  logic                       rb_req,
    input  logic [2:0]                 rb_addr,
    output logic [FRAME_W-1:0]         rb_data,
    output logic                       rb_vld,
    output logic [1:0]                 o_state
);
    localparam int AW    = 3;
    localparam int FBITS = AW + FRAME_W + 1;
    localparam int CW    = $clog2(FBITS);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAKE = 2'd2, RUN = 2'd3} state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_bit_cnt;
    logic [FBITS-2:0]           r_shift;
    logic [NFRAMES-1:0]         r_mask;
    logic [FRAME_W*NFRAMES-1:0] r_cfg;
    logic                       r_err;
    logic                       r_sdi_rdy;
    logic                       r_prog;
    logic                       r_done;
    logic                       r_wake_cnt;
    logic [FRAME_W-1:0]         r_rb_data;
    logic                       r_rb_vld;

    logic                       w_take;
    logic                       w_last;
    logic [AW-1:0]              w_addr;
    logic [FRAME_W-1:0]         w_data;
    logic                       w_par_ok;
    logic                       w_wr;
    logic [NFRAMES-1:0]         w_wr_mask;
    logic [NFRAMES-1:0]         w_mask_nxt;

    // Handshake: a serial bit transfers on a rising edge where sdi_vld and sdi_rdy are both high.
    assign w_take     = sdi_vld & r_sdi_rdy;
    assign w_last     = (r_bit_cnt == CW'(FBITS - 1));
    assign w_addr     = r_shift[AW-1:0];
    assign w_data     = r_shift[AW+FRAME_W-1:AW];
    assign w_par_ok   = ~(^{sdi, r_shift});
    assign w_wr       = (r_state == LOAD) & ~start & w_take & w_last & w_par_ok;
    assign w_wr_mask  = w_wr ? (NFRAMES'(1) << w_addr) : '0;
    assign w_mask_nxt = r_mask | w_wr_mask;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_mask     <= '0;
            r_err      <= 1'b0;
            r_sdi_rdy  <= 1'b0;
            r_prog     <= 1'b1;
            r_done     <= 1'b0;
            r_wake_cnt <= 1'b0;
        end else if (start) begin
            // A start in any state begins a fresh load; cbit is kept until frames are rewritten.
            r_state   <= LOAD;
            r_bit_cnt <= '0;
            r_mask    <= '0;
            r_err     <= 1'b0;
            r_sdi_rdy <= 1'b1;
            r_prog    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_take) begin
                        if (w_last) begin
                            r_bit_cnt <= '0;
                            if (w_par_ok) begin
                                r_mask <= w_mask_nxt;
                                if (&w_mask_nxt) begin
                                    r_state    <= WAKE;
                                    r_sdi_rdy  <= 1'b0;
                                    r_wake_cnt <= 1'b0;
                                end
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= {sdi, r_shift[FBITS-2:1]};
                        end
                    end
                end
                WAKE: begin
                    if (r_wake_cnt) begin
                        r_state <= RUN;
                        r_prog  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_wake_cnt <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cfg <= '0;
        end else if (w_wr) begin
            r_cfg[w_addr*FRAME_W +: FRAME_W] <= w_data;
        end
    end

    // Reads the bank before this edge's write lands, so a colliding request sees old data.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rb_data <= '0;
            r_rb_vld  <= 1'b0;
        end else begin
            r_rb_vld <= rb_req;
            if (rb_req) begin
                r_rb_data <= r_cfg[rb_addr*FRAME_W +: FRAME_W];
            end
        end
    end

    assign cbit    = r_cfg;
    assign cbitb   = ~r_cfg;
    assign sdi_rdy = r_sdi_rdy;
    assign prog    = r_prog;
    assign done    = r_done;
    assign err     = r_err;
    assign rb_data = r_rb_data;
    assign rb_vld  = r_rb_vld;
    assign o_state = r_state;

endmodule
